fetch_sequencer: RTL

Instruction-fetch sequencer for the A09 datapath: drives the PC, MAR, address mux, memory read strobe and IR load so that every instruction is fetched, latched and handed to the execute unit in a fixed sequence. After reset it runs the reset-vector sequence (clear PC/MAR, load reset vector), then loops fetch → read → increment → execute. It sits between the memory interface and the execute controller, and supports halt/resume at instruction boundaries.

---
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch sequencer for the A09 datapath.
// After reset it runs the reset-vector sequence, then loops fetch -> read ->
// increment -> execute, with halt/resume only at instruction boundaries.
// Optional feature macro: MEM_WAIT_EN (memory wait states with read timeout
// and a sticky bus-error flag). When undefined, every read takes one cycle.
module fetch_sequencer #(
  parameter int PC_SELECT_SIZE   = 3,
  parameter int ADDR_SELECT_SIZE = 2,
  parameter int PC_SRC_VECTOR    = 2,
  parameter int PC_SRC_INC       = 1,
  parameter int ADDR_SRC_PC      = 0,
  parameter int WAIT_LIMIT       = 15
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        halt_i,
  input  logic                        resume_i,
  input  logic                        mem_rdy_i,
  input  logic                        exec_done_i,
  output logic                        pc_rst_no,
  output logic                        pc_ld_no,
  output logic [PC_SELECT_SIZE-1:0]   pc_src_o,
  output logic                        mar_rst_no,
  output logic                        mar_ld_no,
  output logic [ADDR_SELECT_SIZE-1:0] addr_src_o,
  output logic                        mem_rd_no,
  output logic                        ir_ld_no,
  output logic                        exec_start_o,
  output logic                        halted_o,
  output logic                        bus_err_o
);

  localparam logic [2:0] S_VEC1  = 3'd0;
  localparam logic [2:0] S_VEC2  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_INC   = 3'd4;
  localparam logic [2:0] S_EXEC  = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  logic [2:0] state_q, state_d;
  logic       read_done;     // IR may latch the memory data this cycle
  logic       read_timeout;  // give up on the current read

`ifdef MEM_WAIT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       bus_err_q, bus_err_d;

  // Read completes on mem_rdy_i; a ready at the limit still wins over timeout.
  always_comb begin
    read_done    = mem_rdy_i;
    read_timeout = !mem_rdy_i && (wait_cnt_q == 4'(WAIT_LIMIT));
  end

  // Wait counter restarts when a read begins and counts unready read cycles;
  // the error flag is sticky until reset.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == S_FETCH && !halt_i) begin
      wait_cnt_d = '0;
    end else if (state_q == S_READ && !mem_rdy_i && !read_timeout) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    bus_err_d = bus_err_q | ((state_q == S_READ) && read_timeout);
  end

  // Wait-state bookkeeping registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  // Zero-wait memory: the read always finishes in its first cycle.
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy_i;
  assign read_done      = 1'b1;
  assign read_timeout   = 1'b0;
  assign bus_err_o      = 1'b0;
`endif

  // Next-state selection for the fetch loop.
  always_comb begin
    state_d = S_VEC1;
    case (state_q)
      S_VEC1:  state_d = S_VEC2;
      S_VEC2:  state_d = S_FETCH;
      S_FETCH: state_d = halt_i ? S_HALT : S_READ;
      S_READ: begin
        if (read_done)         state_d = S_INC;
        else if (read_timeout) state_d = S_HALT;
        else                   state_d = S_READ;
      end
      S_INC:   state_d = S_EXEC;
      S_EXEC:  state_d = exec_done_i ? S_FETCH : S_EXEC;
      S_HALT:  state_d = resume_i ? S_FETCH : S_HALT;
      default: state_d = S_VEC1;
    endcase
  end

  // State register; reset lands in the first reset-vector step immediately.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_VEC1;
    else           state_q <= state_d;
  end

  // Datapath strobes decoded from the current state.
  always_comb begin
    pc_rst_no    = 1'b1;
    pc_ld_no     = 1'b1;
    pc_src_o     = '0;
    mar_rst_no   = 1'b1;
    mar_ld_no    = 1'b1;
    addr_src_o   = '0;
    mem_rd_no    = 1'b1;
    ir_ld_no     = 1'b1;
    exec_start_o = 1'b0;
    halted_o     = 1'b0;
    case (state_q)
      S_VEC1: begin
        pc_rst_no  = 1'b0;
        mar_rst_no = 1'b0;
      end
      S_VEC2: begin
        pc_src_o = PC_SELECT_SIZE'(PC_SRC_VECTOR);
        pc_ld_no = 1'b0;
      end
      S_FETCH: begin
        if (!halt_i) begin
          addr_src_o = ADDR_SELECT_SIZE'(ADDR_SRC_PC);
          mar_ld_no  = 1'b0;
        end
      end
      S_READ: begin
        mem_rd_no = 1'b0;
        if (read_done) ir_ld_no = 1'b0;
      end
      S_INC: begin
        pc_src_o     = PC_SELECT_SIZE'(PC_SRC_INC);
        pc_ld_no     = 1'b0;
        exec_start_o = 1'b1;
      end
      S_HALT:  halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule
